// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM bank and the motor controller that drives it.
package pwm_pkg;

    // Default counter / period / duty width.
    localparam int PWM_CNT_W  = 15;

    // Upper bounds for the generic duty-vector helper.
    localparam int PWM_MAX_CH = 16;
    localparam int PWM_MAX_W  = 32;

    typedef logic [PWM_MAX_CH*PWM_MAX_W-1:0] duty_vec_t;

    // Output override encoding; brake outranks coast.
    typedef enum logic [1:0] {
        OVR_NONE  = 2'b00,
        OVR_COAST = 2'b01,
        OVR_BRAKE = 2'b10
    } ovr_e;

    function automatic ovr_e ovr_sel(input logic brake, input logic coast);
        if (brake) return OVR_BRAKE;
        if (coast) return OVR_COAST;
        return OVR_NONE;
    endfunction

    // Extract channel ch (w bits wide) from a flattened duty vector.
    function automatic logic [PWM_MAX_W-1:0] duty_slice(input duty_vec_t vec, input int ch,
                                                        input int w);
        duty_vec_t            sh;
        logic [PWM_MAX_W-1:0] mask;
        sh   = vec >> (ch * w);
        mask = (w >= PWM_MAX_W) ? '1 : ((PWM_MAX_W'(1) << w) - PWM_MAX_W'(1));
        return sh[PWM_MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/pwm_ramp.sv
// Per-channel active-duty register: on each apply strobe it moves toward the
// target, either in one go (RAMP_STEP=0) or by at most RAMP_STEP, landing
// exactly on the target without overshoot.
module pwm_ramp
    import pwm_pkg::*;
#(
    parameter int CNT_W     = PWM_CNT_W,
    parameter int RAMP_STEP = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             apply_i,
    input  logic [CNT_W-1:0] target_i,
    output logic [CNT_W-1:0] active_o
);

    localparam logic [CNT_W-1:0] STEP = CNT_W'(RAMP_STEP);

    logic [CNT_W-1:0] active_q, active_d, gap;

    // Next active duty: hold, jump, or slew one bounded step toward the target.
    always_comb begin
        active_d = active_q;
        gap      = '0;
        if (apply_i) begin
            if (RAMP_STEP == 0) begin
                active_d = target_i;
            end else if (target_i >= active_q) begin
                gap      = target_i - active_q;
                active_d = (gap > STEP) ? active_q + STEP : target_i;
            end else begin
                gap      = active_q - target_i;
                active_d = (gap > STEP) ? active_q - STEP : target_i;
            end
        end
    end

    // Active duty register.
    always_ff @(posedge clk_i) begin
        if (rst_i) active_q <= '0;
        else       active_q <= active_d;
    end

    assign active_o = active_q;

endmodule

// File: rtl/pwm_bank.sv
// N-channel PWM bank sharing one programmable-period counter. Period and duty
// requests are captured into shadows and only reach the active registers at
// the period wrap, so outputs never change shape mid-period.
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int CNT_W      = PWM_CNT_W,
    parameter int PERIOD_RST = 32767,
    parameter int RAMP_STEP  = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [CNT_W-1:0]      period_i,
    input  logic [N_CH*CNT_W-1:0] duty_i,
    input  logic                  load_i,
    input  logic [N_CH-1:0]       brake_i,
    input  logic [N_CH-1:0]       coast_i,
    output logic [N_CH-1:0]       enable_o,
    output logic                  wrap_tick_o,
    output logic                  busy_o
);

    localparam logic [CNT_W-1:0] PER_RST = CNT_W'(PERIOD_RST);

    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [CNT_W-1:0]            act_per_q, act_per_d;
    logic [CNT_W-1:0]            sh_per_q, sh_per_d;
    logic                        pending_q, pending_d;
    logic                        wrap_tick_q;
    logic                        wrap;
    logic [N_CH-1:0]             en_q, en_d;
    logic [N_CH-1:0]             duty_diff;
    logic [N_CH-1:0][CNT_W-1:0]  sh_duty, act_duty;
    duty_vec_t                   duty_ext;

    assign wrap = (cnt_q == act_per_q);

    // Zero-extend the flat duty bus so the package slicer can address it.
    always_comb begin
        duty_ext                   = '0;
        duty_ext[N_CH*CNT_W-1:0]   = duty_i;
    end

    // Counter, period shadow/active and pending next-state. A load coinciding
    // with a wrap lands in the shadow after the old shadow has been applied.
    always_comb begin
        cnt_d     = wrap ? '0 : cnt_q + CNT_W'(1);
        act_per_d = wrap ? sh_per_q : act_per_q;
        sh_per_d  = load_i ? period_i : sh_per_q;
        pending_d = load_i ? 1'b1 : (wrap ? 1'b0 : pending_q);
    end

    // Shared timing state; reset aborts the running period outright.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            act_per_q   <= PER_RST;
            sh_per_q    <= PER_RST;
            pending_q   <= 1'b0;
            wrap_tick_q <= 1'b0;
            en_q        <= '0;
        end else begin
            cnt_q       <= cnt_d;
            act_per_q   <= act_per_d;
            sh_per_q    <= sh_per_d;
            pending_q   <= pending_d;
            wrap_tick_q <= wrap;
            en_q        <= en_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CNT_W-1:0] sh_q;
        logic             en_nxt;

        // Duty shadow: last load before the wrap wins.
        always_ff @(posedge clk_i) begin
            if (rst_i)       sh_q <= '0;
            else if (load_i) sh_q <= CNT_W'(duty_slice(duty_ext, i, CNT_W));
        end

        pwm_ramp #(
            .CNT_W     (CNT_W),
            .RAMP_STEP (RAMP_STEP)
        ) u_ramp (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .apply_i  (wrap),
            .target_i (sh_q),
            .active_o (act_duty[i])
        );

        // Channel output: overrides first, otherwise unsigned compare.
        always_comb begin
            unique case (ovr_sel(brake_i[i], coast_i[i]))
                OVR_BRAKE: en_nxt = 1'b1;
                OVR_COAST: en_nxt = 1'b0;
                default:   en_nxt = (cnt_q < act_duty[i]);
            endcase
        end

        assign sh_duty[i]   = sh_q;
        assign en_d[i]      = en_nxt;
        assign duty_diff[i] = (act_duty[i] != sh_duty[i]);
    end

    assign enable_o    = en_q;
    assign wrap_tick_o = wrap_tick_q;
    assign busy_o      = pending_q | (|duty_diff);

endmodule

// File: tb/tb_pwm_bank.sv
// Bench for pwm_bank: two instances (immediate apply and RAMP_STEP=2) share
// the same stimulus and are compared every cycle against a behavioural model,
// with directed period-level checks from the test plan layered on top.
module tb_pwm_bank;

    localparam int N_CH  = 4;
    localparam int CNT_W = 15;
    localparam int PRST  = 31;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst, load;
    logic [CNT_W-1:0]      period;
    logic [N_CH*CNT_W-1:0] duty;
    logic [N_CH-1:0]       brake, coast;
    logic [N_CH-1:0]       en0, en1;
    logic                  wt0, wt1, busy0, busy1;

    pwm_bank #(.N_CH(N_CH), .CNT_W(CNT_W), .PERIOD_RST(PRST), .RAMP_STEP(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .period_i(period), .duty_i(duty), .load_i(load),
        .brake_i(brake), .coast_i(coast), .enable_o(en0), .wrap_tick_o(wt0), .busy_o(busy0));

    pwm_bank #(.N_CH(N_CH), .CNT_W(CNT_W), .PERIOD_RST(PRST), .RAMP_STEP(2)) dut1 (
        .clk_i(clk), .rst_i(rst), .period_i(period), .duty_i(duty), .load_i(load),
        .brake_i(brake), .coast_i(coast), .enable_o(en1), .wrap_tick_o(wt1), .busy_o(busy1));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model state, index 0 = immediate apply, 1 = slew of 2/period.
    int              m_cnt[2], m_per[2], m_sper[2];
    bit              m_pend[2], m_wt[2];
    int              m_duty[2][N_CH], m_sduty[2][N_CH];
    logic [N_CH-1:0] m_en[2];
    int              m_step[2] = '{0, 2};

    function automatic int slew(input int cur, input int tgt, input int s);
        if (s == 0)   return tgt;
        if (tgt > cur) return (tgt - cur > s) ? cur + s : tgt;
        return (cur - tgt > s) ? cur - s : tgt;
    endfunction

    function automatic bit exp_busy(input int k);
        bit b = m_pend[k];
        for (int c = 0; c < N_CH; c++) if (m_duty[k][c] != m_sduty[k][c]) b = 1'b1;
        return b;
    endfunction

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_step();
        bit w;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_cnt[k] = 0; m_per[k] = PRST; m_sper[k] = PRST; m_pend[k] = 0;
                m_en[k] = '0; m_wt[k] = 0;
                for (int c = 0; c < N_CH; c++) begin m_duty[k][c] = 0; m_sduty[k][c] = 0; end
            end else begin
                w = (m_cnt[k] == m_per[k]);
                for (int c = 0; c < N_CH; c++)
                    m_en[k][c] = brake[c] ? 1'b1 : (coast[c] ? 1'b0 : (m_cnt[k] < m_duty[k][c]));
                m_wt[k] = w;
                if (w) begin
                    m_per[k] = m_sper[k];
                    for (int c = 0; c < N_CH; c++)
                        m_duty[k][c] = slew(m_duty[k][c], m_sduty[k][c], m_step[k]);
                    m_pend[k] = 0;
                end
                m_cnt[k] = w ? 0 : m_cnt[k] + 1;
                if (load) begin
                    m_sper[k] = int'(period);
                    for (int c = 0; c < N_CH; c++) m_sduty[k][c] = int'(duty[c*CNT_W +: CNT_W]);
                    m_pend[k] = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("enable_imm",  32'(en0),   32'(m_en[0]));
        chk("enable_ramp", 32'(en1),   32'(m_en[1]));
        chk("wrap_imm",    32'(wt0),   32'(m_wt[0]));
        chk("wrap_ramp",   32'(wt1),   32'(m_wt[1]));
        chk("busy_imm",    32'(busy0), 32'(exp_busy(0)));
        chk("busy_ramp",   32'(busy1), 32'(exp_busy(1)));
    endtask

    // One clock: model, edge, sample 1ns later, return at the falling edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic wait_wrap(input int k);
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            seen = (k == 0) ? wt0 : wt1;
        end
        if (!seen) chk("wrap_timeout", 32'd0, 32'd1);
    endtask

    task automatic count_hi(input int ch, input int k, output int hi);
        hi = 0;
        repeat (10) begin
            tick();
            hi += int'((k == 0) ? en0[ch] : en1[ch]);
        end
    endtask

    task automatic set_duty(input int ch, input int val);
        duty[ch*CNT_W +: CNT_W] = CNT_W'(val);
    endtask

    task automatic load_now();
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    int hi, hic[N_CH];
    int ramp_exp[5] = '{2, 4, 6, 7, 7};

    initial begin
        rst = 1'b1; load = 1'b0; period = '0; duty = '0; brake = '0; coast = '0;
        tick();
        tick();
        chk("rst_cnt", 32'(dut0.cnt_q), 32'd0);
        rst = 1'b0;

        // Basic 3/10 PWM on channel 0.
        period = CNT_W'(9); set_duty(0, 3);
        load_now();
        wait_wrap(0);
        count_hi(0, 0, hi); chk("duty3_p1", 32'(hi), 32'd3);
        chk("wrap_every10", 32'(wt0), 32'd1);
        count_hi(0, 0, hi); chk("duty3_p2", 32'(hi), 32'd3);

        // Mid-period load at cnt=4 must not disturb the running period.
        hi = 0;
        for (int t = 0; t < 10; t++) begin
            if (t == 4) begin set_duty(0, 7); load = 1'b1; end
            tick();
            load = 1'b0;
            hi += int'(en0[0]);
        end
        chk("midload_cur", 32'(hi), 32'd3);
        count_hi(0, 0, hi); chk("midload_next", 32'(hi), 32'd7);

        // Duty boundaries against period 9.
        set_duty(0, 0); set_duty(1, 10); set_duty(2, 32767); set_duty(3, 9);
        load_now();
        wait_wrap(0);
        for (int c = 0; c < N_CH; c++) hic[c] = 0;
        repeat (10) begin
            tick();
            for (int c = 0; c < N_CH; c++) hic[c] += int'(en0[c]);
        end
        chk("duty0_const0",   32'(hic[0]), 32'd0);
        chk("duty10_const1",  32'(hic[1]), 32'd10);
        chk("dutymax_const1", 32'(hic[2]), 32'd10);
        chk("duty_eq_period", 32'(hic[3]), 32'd9);

        // Brake/coast priority on channel 1 with duty 5.
        set_duty(1, 5);
        load_now();
        wait_wrap(0);
        brake[1] = 1'b1; coast[1] = 1'b1;
        tick(); chk("brake_wins", 32'(en0[1]), 32'd1);
        brake[1] = 1'b0;
        tick(); chk("coast_only", 32'(en0[1]), 32'd0);
        coast[1] = 1'b0;
        repeat (12) tick();

        // Zero period: counter parked at 0, tick every cycle.
        period = '0;
        load_now();
        wait_wrap(0);
        repeat (5) begin tick(); chk("period0_tick", 32'(wt0), 32'd1); end
        period = CNT_W'(9);
        load_now();
        repeat (4) tick();

        // Soft start 0 -> 7 with step 2.
        rst = 1'b1; tick(); rst = 1'b0;
        duty = '0; period = CNT_W'(9);
        load_now();
        wait_wrap(1);
        set_duty(0, 7);
        load_now();
        wait_wrap(1);
        for (int p = 0; p < 5; p++) begin
            count_hi(0, 1, hi);
            chk("ramp_hi", 32'(hi), 32'(ramp_exp[p]));
            if (p == 1) chk("ramp_busy", 32'(busy1), 32'd1);
            if (p == 2) chk("ramp_idle", 32'(busy1), 32'd0);
        end

        // Reset in the middle of a high phase.
        repeat (5) tick();
        chk("pre_rst_high", 32'(en0[0]), 32'd1);
        rst = 1'b1;
        tick();
        chk("rst_en",  32'(en0), 32'd0);
        chk("rst_cnt2", 32'(dut0.cnt_q), 32'd0);
        rst = 1'b0;
        hi = 0;
        repeat (40) begin tick(); hi += int'(en0[0]) + int'(en1[0]); end
        chk("post_rst_quiet", 32'(hi), 32'd0);

        // Randomised traffic.
        for (int i = 0; i < 500; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            load  = ($urandom_range(0, 11) == 0);
            if (load) begin
                period = CNT_W'($urandom_range(0, 12));
                for (int c = 0; c < N_CH; c++)
                    set_duty(c, ($urandom_range(0, 9) == 0) ? 32767 : int'($urandom_range(0, 14)));
            end
            for (int c = 0; c < N_CH; c++) begin
                brake[c] = ($urandom_range(0, 7) == 0);
                coast[c] = ($urandom_range(0, 7) == 0);
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
